// File: rtl/mbist_sequencer.sv
// MBIST run controller: launches March C, March A and APNPSF in order and tracks the fault budget.
// Optional watchdog per algorithm is compiled in when MBIST_WATCHDOG_EN is defined.
module mbist_sequencer #(
  parameter int unsigned          ADDR_WIDTH = 16,
  parameter int unsigned          TMO_WIDTH  = 24,
  parameter logic [TMO_WIDTH-1:0] TMO_LIMIT  = 24'hFFFFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            algo_sel,
  input  logic                  error_exceed_ignore,
  input  logic [ADDR_WIDTH-1:0] allowable_faulty,
  input  logic                  error,
  input  logic                  marchc_complete,
  input  logic                  marcha_complete,
  input  logic                  apnpsf_complete,
  output logic                  marchc_en,
  output logic                  marcha_en,
  output logic                  apnpsf_en,
  output logic                  force_terminate,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] fail_count,
  output logic [1:0]            cur_algo
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_NEXT, S_TERM, S_DONE} state_t;

  state_t                state_reg, state_next;
  logic [2:0]            pending_reg, pending_next;
  logic [ADDR_WIDTH-1:0] budget_reg, budget_next;
  logic [ADDR_WIDTH-1:0] fail_count_reg, fail_count_next;
  logic [1:0]            cur_algo_reg, cur_algo_next;
  logic                  fail_reg, fail_next;
  logic                  timeout_reg, timeout_next;
  logic [2:0]            en_vec, complete_vec;
  logic                  active_complete, tmo_hit;

  assign complete_vec = {apnpsf_complete, marcha_complete, marchc_complete};

  // Enable bit gi belongs to cur_algo code gi+1; only that algorithm's complete counts.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_en
      assign en_vec[gi] = (state_reg == S_RUN) && (cur_algo_reg == 2'(gi + 1));
    end
  endgenerate
  assign active_complete = |(en_vec & complete_vec);

`ifdef MBIST_WATCHDOG_EN
  logic [TMO_WIDTH-1:0] tmo_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)                  tmo_reg <= '0;
    else if (state_reg == S_LAUNCH) tmo_reg <= '0;
    else if (state_reg == S_RUN)    tmo_reg <= tmo_reg + 1'b1;
  end

  // A complete arriving on the limit cycle still wins over the timeout.
  assign tmo_hit = (state_reg == S_RUN) && (tmo_reg == TMO_LIMIT - 1'b1) && !active_complete;
  assign timeout = timeout_reg;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      pending_reg    <= '0;
      budget_reg     <= '0;
      fail_count_reg <= '0;
      cur_algo_reg   <= '0;
      fail_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      budget_reg     <= budget_next;
      fail_count_reg <= fail_count_next;
      cur_algo_reg   <= cur_algo_next;
      fail_reg       <= fail_next;
      timeout_reg    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg;
    budget_next     = budget_reg;
    fail_count_next = fail_count_reg;
    cur_algo_next   = cur_algo_reg;
    fail_next       = fail_reg;
    timeout_next    = timeout_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          pending_next    = algo_sel;
          budget_next     = allowable_faulty;
          fail_count_next = '0;
          fail_next       = 1'b0;
          timeout_next    = 1'b0;
          cur_algo_next   = 2'd0;
          state_next      = (algo_sel == 3'b000) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (pending_reg[0]) begin
          cur_algo_next   = 2'd1;
          pending_next[0] = 1'b0;
        end else if (pending_reg[1]) begin
          cur_algo_next   = 2'd2;
          pending_next[1] = 1'b0;
        end else begin
          cur_algo_next   = 2'd3;
          pending_next[2] = 1'b0;
        end
        state_next = S_RUN;
      end
      S_RUN: begin
        if (error && (fail_count_reg != '1))
          fail_count_next = fail_count_reg + 1'b1;
        // Overrun uses the count including this cycle's error and beats a same-cycle complete.
        if (((fail_count_next > budget_reg) && !error_exceed_ignore) || tmo_hit) begin
          state_next = S_TERM;
          if (tmo_hit) timeout_next = 1'b1;
        end else if (active_complete) begin
          state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        if (pending_reg != 3'b000) begin
          state_next = S_LAUNCH;
        end else begin
          state_next    = S_DONE;
          cur_algo_next = 2'd0;
          fail_next     = (fail_count_reg > budget_reg) | timeout_reg;
        end
      end
      S_TERM: begin
        state_next    = S_DONE;
        cur_algo_next = 2'd0;
        fail_next     = (fail_count_reg > budget_reg) | timeout_reg;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    {apnpsf_en, marcha_en, marchc_en} = en_vec;
    force_terminate = (state_reg == S_TERM);
    busy            = (state_reg == S_LAUNCH) || (state_reg == S_RUN) ||
                      (state_reg == S_NEXT)   || (state_reg == S_TERM);
    done            = (state_reg == S_DONE);
    fail            = fail_reg;
    fail_count      = fail_count_reg;
    cur_algo        = cur_algo_reg;
  end

endmodule

// File: doc/mbist_sequencer.md
Name: mbist_sequencer

Overview:
- Top-level run controller for the MBIST decoder.
- On a start pulse it launches the selected algorithms one at a time, in the fixed order March C, March A, APNPSF: raises that algorithm's enable, waits for its complete pulse, then moves on.
- Accumulates the decoder's per-cycle error flag against the allowable-faulty budget and asserts force_terminate when the budget is exceeded and exceeding is not ignored.
- Reports done, pass/fail and the fault count to the test host.

Parameters:
- ADDR_WIDTH, 16, width of the allowable_faulty budget and of fail_count.
- TMO_WIDTH, 24, width of the watchdog counter (optional feature only).
- TMO_LIMIT, 24'hFFFFFF, maximum cycles one algorithm may stay enabled (optional feature only).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  single-cycle run request; honoured only in IDLE or DONE.
- algo_sel  input  3  bit0 = March C, bit1 = March A, bit2 = APNPSF; sampled on start.
- error_exceed_ignore  input  1  1 = never terminate on budget overrun.
- allowable_faulty  input  ADDR_WIDTH  fault budget; sampled on start.
- error  input  1  per-cycle decoder mismatch flag.
- marchc_complete / marcha_complete / apnpsf_complete  input  1 each  decoder completion pulses.
- marchc_en / marcha_en / apnpsf_en  output  1 each  algorithm enables to the decoder, at most one high.
- force_terminate  output  1  abort request to the decoder.
- busy  output  1  high from launch until DONE.
- done  output  1  sticky; high in DONE.
- fail  output  1  valid while done.
- timeout  output  1  watchdog flag; tied 0 when the optional feature is compiled out.
- fail_count  output  ADDR_WIDTH  saturating fault count for the current run.
- cur_algo  output  2  0 = none, 1 = March C, 2 = March A, 3 = APNPSF.

Behaviour:
- Reset: synchronous, active-low; one clock domain. While rst_n = 0 at a rising edge, every output goes to 0 and the FSM goes to IDLE. The same applies on a reset mid-run: all enables drop at that edge.
- States: IDLE, LAUNCH, RUN, NEXT, TERM, DONE.
- IDLE/DONE:
  - On start, latch algo_sel into pending mask, latch allowable_faulty, clear fail_count / fail / timeout / done.
  - Go to LAUNCH; if the mask is 0, go straight to DONE with fail = 0.
- LAUNCH:
  - Select the lowest set pending bit, set cur_algo, clear that pending bit.
  - Drive the matching *_en at the next edge and enter RUN.
  - Latency: start at edge N gives en high from N+2.
- RUN:
  - Hold *_en high.
  - Count one fault per cycle with error = 1; fail_count saturates at all-ones.
  - Only the active algorithm's complete is honoured; others are ignored.
  - On complete: en low at the next edge, go to NEXT.
- NEXT: if pending != 0 go to LAUNCH, else go to DONE.
- Budget overrun (checked every RUN cycle, using the post-increment count):
  - If the count > allowable_faulty and error_exceed_ignore = 0: drop the enable, raise force_terminate for exactly one cycle (TERM), then DONE with fail = 1.
  - If error_exceed_ignore = 1: the run continues.
- Verdict: in DONE, fail = (fail_count > allowable_faulty) | timeout.
- Same-cycle error and complete: the error is counted first, then the overrun check is made.
  - If it overruns and is not ignored, TERM takes priority over NEXT.
- start outside IDLE/DONE is ignored. Changes to algo_sel mid-run are ignored.
- busy = 1 in LAUNCH, RUN, NEXT and TERM.
- cur_algo returns to 0 in DONE.

Optional Feature:
- MBIST_WATCHDOG_EN defined:
  - A TMO_WIDTH counter clears on each LAUNCH and increments every RUN cycle.
  - On reaching TMO_LIMIT without a complete: set timeout = 1, go to TERM (one-cycle force_terminate), then DONE with fail = 1.
  - The timeout path applies regardless of error_exceed_ignore.
- Undefined: no counter is built, timeout is constant 0, and RUN waits indefinitely for complete.

Test Plan:
- algo_sel = 3'b111, no errors, complete pulses 20 cycles after each en -> en order C, A, APNPSF, one-hot, each dropped the cycle after its complete; done = 1, fail = 0, fail_count = 0.
- algo_sel = 3'b101, allowable_faulty = 2, 2 error pulses in March C -> March A skipped, APNPSF runs, fail_count = 2, fail = 0.
- algo_sel = 3'b001, allowable_faulty = 1, ignore = 0, errors on 2 consecutive cycles -> force_terminate high exactly 1 cycle after the 2nd error edge, then done = 1, fail = 1, fail_count = 2.
- Same as above with ignore = 1, 5 errors -> no force_terminate, run completes, fail_count = 5, fail = 1.
- rst_n low mid-RUN (March A active) -> next edge: all outputs 0, FSM in IDLE; a new start with algo_sel = 3'b010 restarts cleanly. Also: algo_sel = 0 with start -> done next cycles, fail = 0.
- MBIST_WATCHDOG_EN with TMO_LIMIT = 100, complete never sent -> timeout = 1 and force_terminate pulse after 100 RUN cycles; done = 1, fail = 1.
